// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch unit: FSM states, branch kinds, reset PC and
// helpers that turn instruction offset fields into byte displacements.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10
    } fetch_state_t;

    localparam logic [2:0] JT_B    = 3'b000;
    localparam logic [2:0] JT_BL   = 3'b001;
    localparam logic [2:0] JT_BCY  = 3'b010;
    localparam logic [2:0] JT_BNCY = 3'b011;
    localparam logic [2:0] JT_BR   = 3'b100;
    localparam logic [2:0] JT_BLTZ = 3'b101;
    localparam logic [2:0] JT_BZ   = 3'b110;
    localparam logic [2:0] JT_BNZ  = 3'b111;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Word offsets are sign-extended and scaled to bytes.
    function automatic logic [31:0] long_disp(input logic [25:0] off);
        return {{4{off[25]}}, off, 2'b00};
    endfunction

    function automatic logic [31:0] short_disp(input logic [15:0] off);
        return {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_branch_resolve.sv
// Purely combinational next-PC selection for the instruction in EXEC.
// Only the low 26 instruction bits carry offsets, so only those are wired in.
module branch_resolve
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr,
    input  logic        jmp_instr,
    input  logic [2:0]  jmp_type,
    input  logic        jmp_reg,
    input  logic [31:0] rs_val,
    input  logic        carry,
    output logic [31:0] next_pc
);

    logic [31:0] seq_pc;
    logic [31:0] target;
    logic        taken;

    always_comb begin
        seq_pc = pc + 32'd4;
        taken  = 1'b0;
        if (jmp_instr) begin
            case (jmp_type)
                JT_B, JT_BL, JT_BR: taken = 1'b1;
                JT_BCY:             taken = carry;
                JT_BNCY:            taken = ~carry;
                JT_BLTZ:            taken = rs_val[31];
                JT_BZ:              taken = (rs_val == 32'd0);
                JT_BNZ:             taken = (rs_val != 32'd0);
                default:            taken = 1'b0;
            endcase
        end

        // Register targets are used as-is, low bits included.
        if (jmp_reg || (jmp_type == JT_BR)) begin
            target = rs_val;
        end else if (jmp_type[2]) begin
            target = seq_pc + short_disp(instr[15:0]);
        end else begin
            target = seq_pc + long_disp(instr);
        end

        next_pc = taken ? target : seq_pc;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch sequencer: requests a word at pc, holds it while the core
// executes, then advances pc to the resolved next address.
//
//   state | meaning
//   IDLE  | one cycle after reset, no request
//   FETCH | imem_req high at pc, waiting for imem_ready
//   EXEC  | instr held and valid, waiting for exec_done
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        jmp_instr,
    input  logic [2:0]  jmp_type,
    input  logic        jmp_reg,
    input  logic [31:0] rs_val,
    input  logic        alu_carry,
    input  logic        carry_we,
    output logic [31:0] link_pc,
    output logic [31:0] pc
);

    fetch_state_t state;
    logic         carry;
    logic [31:0]  next_pc;

    branch_resolve u_branch_resolve (
        .pc        (pc),
        .instr     (instr[25:0]),
        .jmp_instr (jmp_instr),
        .jmp_type  (jmp_type),
        .jmp_reg   (jmp_reg),
        .rs_val    (rs_val),
        .carry     (carry),
        .next_pc   (next_pc)
    );

    // Branches resolved this cycle see the carry from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            instr <= 32'h0000_0000;
            carry <= 1'b0;
        end else begin
            if (carry_we) begin
                carry <= alu_carry;
            end
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (imem_ready) begin
                        instr <= imem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        pc    <= next_pc;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state flops, so they are glitch-free.
    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == EXEC);
    assign imem_addr   = pc;
    assign link_pc     = pc + 32'd4;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, the address of the first fetch after reset.
REQ-003 SHALL have the following ports, one per line:
- imem_addr  output 32  byte address of the instruction being fetched
- imem_req  output 1  fetch request to instruction memory
- imem_ready  input 1  memory has placed the word on imem_rdata this cycle
- imem_rdata  input 32  fetched instruction word
- instr  output 32  held instruction, feeds the decode controller
- instr_valid  output 1  instr is stable and executing
- exec_done  input 1  core finished executing instr this cycle
- jmp_instr  input 1  decoded instruction is a branch (from controller)
- jmp_type  input 3  branch kind (from controller)
- jmp_reg  input 1  target comes from register (br)
- rs_val  input 32  rs register value, used for br target and bltz/bz/bnz test
- alu_carry  input 1  ALU carry-out
- carry_we  input 1  latch alu_carry into the carry flag
- link_pc  output 32  PC+4 of the current instruction, written back by bl
- pc  output 32  address of the current instruction

Function
REQ-004 SHALL implement an FSM with states IDLE, FETCH and EXEC; IDLE is entered on reset and lasts exactly 1 cycle, then the FSM goes to FETCH.
REQ-005 FETCH SHALL behave as follows:
- imem_req=1 and imem_addr=pc.
- On imem_ready=1, imem_rdata is latched into instr and the FSM goes to EXEC; imem_ready in the first FETCH cycle (zero-wait memory) is accepted.
- The FSM stays in FETCH indefinitely while imem_ready=0.
REQ-006 imem_ready SHALL be ignored outside FETCH.
REQ-007 EXEC SHALL behave as follows:
- instr_valid=1 and imem_req=0.
- instr is held constant.
- The FSM waits for exec_done=1, then updates pc to next_pc and goes to FETCH.
REQ-008 link_pc SHALL equal pc+4 (mod 2^32) in all states.
REQ-009 On exec_done, next_pc SHALL be selected by jmp_instr and jmp_type:
- jmp_instr=0: pc+4.
- 000 b: taken.
- 001 bl: taken.
- 010 bcy: taken if carry=1.
- 011 bncy: taken if carry=0.
- 100 br: taken, target = rs_val.
- 101 bltz: taken if rs_val[31]=1.
- 110 bz: taken if rs_val==0.
- 111 bnz: taken if rs_val!=0.
REQ-010 Targets for taken branches SHALL be:
- jmp_reg=1: target = rs_val.
- jmp_type 000–011: target = pc+4 + (sign-extended instr[25:0] << 2).
- jmp_type 101–111: target = pc+4 + (sign-extended instr[15:0] << 2).
- Not taken: pc+4.
REQ-011 All address arithmetic SHALL be 32-bit and wrap modulo 2^32, with no exception.
REQ-012 The carry flag SHALL update on any cycle where carry_we=1, regardless of state.
REQ-013 When exec_done and carry_we are both 1 in the same cycle, bcy/bncy SHALL use the carry value from before that edge.
REQ-014 rs_val[1:0] SHALL be used unmodified for br targets, with no alignment forcing.
REQ-015 exec_done outside EXEC SHALL be ignored.

Reset
REQ-016 While rst=1 at a clock edge, the unit SHALL set:
- state=IDLE, pc=RESET_PC, instr=32'h0000_0000, carry=0.
- imem_req=0, instr_valid=0.
REQ-017 Reset asserted mid-FETCH or mid-EXEC SHALL abort the operation.
REQ-018 An imem_ready arriving in the same cycle as rst SHALL be discarded.

Structure
REQ-019 A shared package SHALL hold:
- state encoding: IDLE=2'b00, FETCH=2'b01, EXEC=2'b10.
- jmp_type encodings JT_B … JT_BNZ.
- RESET_PC default.
REQ-020 The controller SHALL import the same jmp_type constants from that package.
REQ-021 The unit SHALL contain one combinational sub-module, branch_resolve, taking pc, instr, jmp_instr, jmp_type, jmp_reg, rs_val and carry, and returning next_pc.
REQ-022 pc, instr, carry and state SHALL be the only registers.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset then zero-wait memory returning 32'h0000_0001 -> imem_req high from cycle 2 with imem_addr=0; instr_valid high cycle 3; after exec_done, imem_addr=4.
- Memory with 3 wait cycles -> imem_req held 4 cycles, imem_addr stable, instr latched only on the imem_ready cycle.
- pc=0x100, b with instr[25:0]=26'h3FFFFFE (-2) -> next imem_addr=0x0FC; same offset at pc=0 -> 0xFFFF_FFFC (wrap).
- carry_we=1 with alu_carry=1, later bcy offset +4 at pc=0x20 -> 0x34; bncy at the same point -> 0x24; exec_done with simultaneous carry_we/alu_carry=0 on bcy still takes the branch.
- bz/bnz/bltz with rs_val=0, 5, 0x8000_0000 at pc=0x40, offset 1 -> targets 0x48 or 0x44 per REQ-009; br with rs_val=0x200 -> 0x200; bl -> link_pc=pc+4 during EXEC.
- rst asserted during FETCH wait and during EXEC -> next cycle state IDLE, pc=RESET_PC, instr_valid=0; late imem_ready ignored.
